uart_ram_loader: RTL and testbench

UART_RAM_LOADER -- requirements
Module: uart_ram_loader

---
 rtl/uart_ram_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// uart_ram_loader
// ---------------
// Parses framed byte streams from a UART receiver and writes the payload into
// a byte-wide pulse-table RAM.
//
// Frame format: 0xA5, ADDR, LEN, LEN data bytes, and CSUM only when the
// CHECKSUM_EN macro is defined. CSUM is the XOR of ADDR, LEN and all data bytes.
// With CHECKSUM_EN undefined there is no checksum state and no accumulator, and
// a frame commits right after its last data byte.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. A byte is
// consumed in every cycle where rx_valid is high, so the source may strobe on
// every cycle. Each accepted data byte produces one registered, active-low
// write strobe (ram_we_n) in the following cycle. Every frame ends with exactly
// one single-cycle pulse on either cfg_valid or cfg_err. That pulse appears two
// cycles after the strobe of the final frame byte.
//
// Parameters:
//   DEPTH    number of byte locations in the RAM (default 112)
//   TIMEOUT  maximum idle clk cycles between bytes of one frame
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   rx_data    received byte
//   rx_valid   rx_data strobe
//   ram_addr   RAM write address
//   ram_din    RAM write data
//   ram_we_n   RAM write enable, active-low
//   busy       frame in progress (any state except IDLE)
//   cfg_valid  frame committed without error
//   cfg_err    frame rejected (bad LEN/ADDR, timeout, checksum mismatch)
module uart_ram_loader #(
    parameter int          DEPTH   = 112,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we_n,
    output logic       busy,
    output logic       cfg_valid,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        GET_DATA,
`ifdef CHECKSUM_EN
        GET_CSUM,
`endif
        REPORT
    } state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;       // next write address
    logic [7:0]  len_q, len_d;         // data bytes still expected
    logic        err_q, err_d;         // outcome reported in REPORT
    logic [15:0] cnt_q, cnt_d;         // idle cycles since the last byte
    logic        we_n_q, we_n_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        cfg_err_q, cfg_err_d;
`ifdef CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic start;
    logic in_frame;

    assign start    = rx_valid && (rx_data == 8'hA5);
    assign in_frame = (state_q != IDLE) && (state_q != REPORT);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        err_d       = err_q;
        cnt_d       = '0;
        we_n_d      = 1'b1;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        cfg_valid_d = 1'b0;
        cfg_err_d   = 1'b0;
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
`endif

        if (in_frame) begin
            cnt_d = rx_valid ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GET_ADDR;
                    err_d   = 1'b0;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = GET_LEN;
`ifdef CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    len_d = rx_data;
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    // 9-bit sum so ADDR+LEN cannot wrap past the RAM end.
                    if ((rx_data == 8'd0) ||
                        (({1'b0, addr_q} + {1'b0, rx_data}) > DEPTH_W)) begin
                        err_d   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    we_n_d     = 1'b0;
                    ram_addr_d = addr_q;
                    ram_din_d  = rx_data;
                    addr_d     = addr_q + 8'd1;
                    len_d      = len_q - 8'd1;
`ifdef CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
                    if (len_q == 8'd1) state_d = GET_CSUM;
`else
                    if (len_q == 8'd1) state_d = REPORT;
`endif
                end
            end
`ifdef CHECKSUM_EN
            GET_CSUM: begin
                if (rx_valid) begin
                    err_d   = (rx_data != csum_q);
                    state_d = REPORT;
                end
            end
`endif
            REPORT: begin
                cfg_valid_d = !err_q;
                cfg_err_d   = err_q;
                // A byte arriving here is treated exactly like an IDLE byte.
                if (start) begin
                    state_d = GET_ADDR;
                    err_d   = 1'b0;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout overrides whatever the parser would do this cycle.
        if (in_frame && !rx_valid && ((cnt_q + 16'd1) == TIMEOUT)) begin
            state_d = REPORT;
            err_d   = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            we_n_q      <= 1'b1;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            we_n_q      <= we_n_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we_n  = we_n_q;
    assign busy      = (state_q != IDLE);
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Testbench for uart_ram_loader: directed frames from the requirements list
// followed by randomized frames, all checked against a frame-level reference
// model (expected writes and report pulses with their cycle stamps).
module tb_uart_ram_loader;

    localparam int          DEPTH   = 112;
    localparam logic [15:0] TIMEOUT = 16'd40;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we_n;
    logic       busy;
    logic       cfg_valid;
    logic       cfg_err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_ram_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we_n (ram_we_n),
        .busy     (busy),
        .cfg_valid(cfg_valid),
        .cfg_err  (cfg_err)
    );

    // ---------------- scoreboard ----------------
    // Write entries: {cycle[15:0], addr, data}; report entries: {cycle[15:0], kind}
    // with kind 1 = cfg_valid, 2 = cfg_err.
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_rep_q[$];
    logic [31:0] wr_log[$];
    logic [31:0] rep_log[$];
    int          bad_addr = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          drv_cyc  = 0;
    logic [7:0]  pay[$];

    always @(negedge clk) begin
        if (ram_we_n === 1'b0) begin
            wr_log.push_back({cyc[15:0], ram_addr, ram_din});
            if (ram_addr >= DEPTH) bad_addr++;
        end
        if (cfg_valid === 1'b1) rep_log.push_back({cyc[15:0], 16'd1});
        if (cfg_err === 1'b1)   rep_log.push_back({cyc[15:0], 16'd2});
    end

    function automatic logic [31:0] rep_word(input int c, input int kind);
        return {16'(c), 16'(kind)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_wr_count"}, wr_log.size(), exp_wr_q.size());
        while (wr_log.size() > 0 && exp_wr_q.size() > 0)
            chk({tag, "_wr"}, wr_log.pop_front(), exp_wr_q.pop_front());
        chk({tag, "_rep_count"}, rep_log.size(), exp_rep_q.size());
        while (rep_log.size() > 0 && exp_rep_q.size() > 0)
            chk({tag, "_rep"}, rep_log.pop_front(), exp_rep_q.pop_front());
        chk({tag, "_addr_range"}, bad_addr, 0);
        wr_log.delete(); exp_wr_q.delete(); rep_log.delete(); exp_rep_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        drv_cyc  = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic gap_rand(input int m);
        gap($urandom_range(0, m));
    endtask

    // Sends one frame using pay[] as payload and records the expected
    // writes/report. n_send < len truncates the frame (no report expected).
    task automatic send_frame(input logic [7:0] a, input logic [7:0] l,
                              input logic [7:0] csum_flip, input int gap_max,
                              input int n_send);
        logic [7:0] x;
        send_byte(8'hA5); gap_rand(gap_max);
        send_byte(a);     x = a; gap_rand(gap_max);
        send_byte(l);     x ^= l;
        if (l == 8'd0 || int'(a) + int'(l) > DEPTH) begin
            exp_rep_q.push_back(rep_word(drv_cyc + 2, 2));
            return;
        end
        for (int i = 0; i < n_send; i++) begin
            gap_rand(gap_max);
            send_byte(pay[i]);
            x ^= pay[i];
            exp_wr_q.push_back({16'(drv_cyc + 1), 8'(int'(a) + i), pay[i]});
        end
        if (n_send < int'(l)) return;
`ifdef CHECKSUM_EN
        gap_rand(gap_max);
        send_byte(x ^ csum_flip);
        exp_rep_q.push_back(rep_word(drv_cyc + 2, (csum_flip == 8'd0) ? 1 : 2));
`else
        exp_rep_q.push_back(rep_word(drv_cyc + 2, 1));
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int rc;
        logic [7:0] a, l, f, nb;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we_n", ram_we_n, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        gap(2);

        // Basic three-byte frame.
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h10, 8'd3, 8'h00, 0, 3);
        gap(5);
        compare_logs("basic");
        chk("basic_busy", busy, 0);

        // ADDR+LEN beyond the RAM: error, trailing bytes ignored.
        send_frame(8'h6E, 8'd3, 8'h00, 0, 3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        gap(5);
        compare_logs("overflow");

        // Exactly fills the RAM end, then single byte at the last location.
        pay = '{8'hA5, 8'h5A, 8'hC3};
        send_frame(8'h6D, 8'd3, 8'h00, 1, 3);
        gap(4);
        pay = '{8'h99};
        send_frame(8'h6F, 8'd1, 8'h00, 1, 1);
        gap(4);
        compare_logs("ram_end");

        // LEN of zero.
        send_frame(8'h05, 8'd0, 8'h00, 0, 0);
        gap(4);
        compare_logs("len_zero");

        // Checksum mismatch (correct CSUM 0x13, sent 0x00) when enabled.
        pay = '{8'hAA, 8'hBB};
        send_frame(8'h00, 8'd2, 8'h13, 0, 2);
        gap(4);
        compare_logs("csum");

        // Timeout after two of four data bytes, then a good frame.
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'h20, 8'd4, 8'h00, 0, 2);
        t0 = drv_cyc;
        gap(3);
        chk("timeout_busy_mid", busy, 1);
        gap(int'(TIMEOUT) + 6);
        chk("timeout_rep_count", rep_log.size(), 1);
        if (rep_log.size() > 0) begin
            rc = int'(rep_log[0][31:16]);
            chk("timeout_kind", rep_log[0][15:0], 2);
            chk("timeout_window", (rc >= t0 + int'(TIMEOUT)) && (rc <= t0 + int'(TIMEOUT) + 3), 1);
        end
        rep_log.delete();
        chk("timeout_busy_after", busy, 0);
        compare_logs("timeout");
        pay = '{8'h44, 8'h55};
        send_frame(8'h30, 8'd2, 8'h00, 2, 2);
        gap(4);
        compare_logs("after_timeout");

        // Back-to-back stream with leading noise bytes.
        pay = '{8'h7E};
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h05, 8'd1, 8'h00, 0, 1);
        gap(4);
        compare_logs("b2b");

        // Reset one cycle after the second data byte of a LEN=4 frame.
        pay = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send_frame(8'h40, 8'd4, 8'h00, 0, 2);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we_n", ram_we_n, 1);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_din", ram_din, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        gap(5);
        compare_logs("mid_rst");
        pay = '{8'h12, 8'h34};
        send_frame(8'h08, 8'd2, 8'h00, 1, 2);
        gap(4);
        compare_logs("after_rst");

        // Randomized frames.
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h00;
                send_byte(nb);
            end
            a = 8'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 9))
                0:       l = 8'd0;
                1:       l = 8'($urandom_range(DEPTH - int'(a) + 1, 255));
                default: l = 8'($urandom_range(1, (DEPTH - int'(a) > 16) ? 16 : DEPTH - int'(a)));
            endcase
            f = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            pay.delete();
            for (int i = 0; i < int'(l); i++) pay.push_back(8'($urandom_range(0, 255)));
            send_frame(a, l, f, $urandom_range(0, 3), int'(l));
            gap(4);
            compare_logs("rand");
            chk("rand_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
